cnt_stream_packer: RTL and testbench
====================================

# cnt_stream_packer

Downstream consumer of the leaf interface's counter stream on the host-DMA leaf. It accepts 64-bit counter words (`cnt`/`cnt_vld`/`cnt_ack`) and packs eight per 512-bit beat for the host write path. It frames one run of `num_cnt_read` words per kernel call: the final, possibly partial beat is zero-padded and flagged with `dout_last`, and completion is signalled with a one-cycle `done`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: idle cycles before a partial beat is force-flushed (only with `CNT_FLUSH_TIMEOUT_EN`).
- `clk` in, 1: single clock.
- `reset` in, 1: synchronous, active-high.
- `cnt` in, 64: counter word from leaf interface.
- `cnt_vld` in, 1: `cnt` valid; held until acked.
- `cnt_ack` out, 1: packer accepts; a transfer happens on `cnt_vld && cnt_ack`.
- `num_cnt_read` in, 16: words expected this run.
- `num_cnt_read_valid` in, 1: load strobe for `num_cnt_read`.
- `dout` out, 512: packed beat; word k in bits [64k+63:64k].
- `dout_vld` out, 1: beat valid.
- `dout_ready` in, 1: downstream accepts the beat.
- `dout_last` out, 1: final beat of the run.
- `done` out, 1: one-cycle pulse after the last beat is accepted.
- `timed_out` out, 1: sticky flag, run ended by timeout; cleared on the next load.

## Operation
- Registers:
  - `target` (16b), `rcvd` (16b), `lane` (3b).
  - `buf` (512b), `last_r`.
  - State ∈ {IDLE, FILL, OUT}.
- IDLE:
  - `cnt_ack`=0.
  - On `num_cnt_read_valid` with nonzero value: `target`←value, `rcvd`←0, `lane`←0, `buf`←0, `timed_out`←0, go to FILL.
  - A zero value is ignored: stay in IDLE, no `done`.
- FILL:
  - `cnt_ack`=1, driven as a level from state only, independent of `cnt_vld`.
  - On transfer: `buf[lane]`←`cnt`, `rcvd`←`rcvd`+1, `lane`←`lane`+1 (wraps 7→0).
  - Go to OUT when the transfer fills lane 7 or makes `rcvd`+1==`target`.
  - `last_r`←(`rcvd`+1==`target`).
- OUT:
  - `cnt_ack`=0; `dout`=`buf`, `dout_vld`=1, `dout_last`=`last_r`.
  - Hold until `dout_ready`.
  - On acceptance with `last_r`: pulse `done`, go to IDLE.
  - On acceptance otherwise: clear `buf`, go to FILL.
- Unused lanes of a partial final beat read zero.
- `num_cnt_read_valid` in FILL or OUT is ignored; `target` is not modified mid-run.
- `cnt_vld` in IDLE or OUT is not acked; the word waits upstream.
- Arithmetic:
  - 16-bit unsigned compares; max run 65535 words (8192 beats).
  - `rcvd` never exceeds `target`.
- A synchronous reset in any state:
  - returns to IDLE;
  - clears all registers;
  - drops any in-flight beat with no `done`.

## Timing
- Reset values: `cnt_ack`=0, `dout`=0, `dout_vld`=0, `dout_last`=0, `done`=0, `timed_out`=0.
- All outputs are registered, except `cnt_ack`, which is decoded from the state register.
- Load to first ack: strobe in cycle N → `cnt_ack`=1 in N+1.
- Eighth or last word accepted in cycle N → `dout_vld`=1 in N+1.
- `dout_ready` high in cycle M while in OUT:
  - → `cnt_ack`=1 in M+1 (non-final beat);
  - → `done`=1 in M+1 (final beat).
- Peak throughput is 8 words per 9 cycles with `dout_ready` held high.
- `dout`, `dout_last` and `dout_vld` are stable while `dout_vld`=1 and `dout_ready`=0.

## Configuration
- `CNT_FLUSH_TIMEOUT_EN` defined:
  - An idle counter runs in FILL when `lane`≠0 or `rcvd`≠0; it resets on every transfer.
  - When it reaches `TIMEOUT_CYCLES`, go to OUT with `last_r`=1 and set `timed_out`.
  - Beat handling and `done` are then as for a normal final beat.
  - A run with `rcvd`=0 never times out.
- `CNT_FLUSH_TIMEOUT_EN` undefined:
  - No idle counter; the packer waits in FILL indefinitely.
  - `timed_out` is tied to 0.

## Test plan
- Load 16, feed 0x1..0x10 back-to-back with `dout_ready`=1 → two beats:
  - beat 1 lanes 0–7 = 1..8, `dout_last`=0;
  - beat 2 lanes = 9..16, `dout_last`=1;
  - `done` is one cycle after beat 2 is accepted.
- Load 3, feed 0xA,0xB,0xC → one beat: lanes 0–2 = A,B,C, lanes 3–7 = 0, `dout_last`=1, single `done`.
- Load 9, hold `dout_ready`=0 for 20 cycles after the first beat → `cnt_ack`=0 and `dout` stable throughout; the ninth word is accepted only after `dout_ready`.
- Load 0 → no ack, no beat, no `done`. Then load 5 during FILL of a run of 8 → the strobe is ignored and the run ends after 8 words.
- Assert `reset` in OUT mid-run → all outputs 0 next cycle, no `done`. Then load 1 and feed 0xFF → normal single-beat run.
- `CNT_FLUSH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, load 10, feed 2 words and stop → partial beat (2 words, `dout_last`=1) issued 16 cycles after the last transfer, with `timed_out`=1 and `done` pulsed.

Source files
------------

// File: rtl/cnt_stream_packer.sv
// cnt_stream_packer: packs 64-bit counter words eight per 512-bit beat, one framed run per load.
// Define CNT_FLUSH_TIMEOUT_EN to force-flush a stalled partial beat after TIMEOUT_CYCLES idle cycles.
module cnt_stream_packer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [63:0]  cnt_i,
  input  logic         cnt_vld_i,
  output logic         cnt_ack_o,
  input  logic [15:0]  num_cnt_read_i,
  input  logic         num_cnt_read_valid_i,
  output logic [511:0] dout_o,
  output logic         dout_vld_o,
  input  logic         dout_ready_i,
  output logic         dout_last_o,
  output logic         done_o,
  output logic         timed_out_o
);
  typedef enum logic [1:0] {IDLE, FILL, OUT} state_e;
  state_e state_q;
  logic [15:0] target_q, rcvd_q;
  logic [2:0] lane_q;
  logic [511:0] buf_q;
  logic dout_vld_q, dout_last_q, done_q, timed_out_q;
  logic xfer, fin, flush;
  assign cnt_ack_o = state_q == FILL;
  assign xfer = cnt_ack_o && cnt_vld_i;
  assign fin = rcvd_q + 16'd1 == target_q;
`ifdef CNT_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q;
  logic stalled;
  // An empty run has nothing to flush, so it never starts the idle count.
  assign stalled = state_q == FILL && !cnt_vld_i && (lane_q != 3'd0 || rcvd_q != 16'd0);
  assign flush = stalled && idle_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i)
    if (reset_i || !stalled) idle_q <= '0;
    else if (!flush) idle_q <= idle_q + TW'(1);
`else
  assign flush = 1'b0 && TIMEOUT_CYCLES > 0;
`endif
  always_ff @(posedge clk_i) begin
    done_q <= 1'b0;
    if (reset_i) begin
      state_q <= IDLE;
      target_q <= '0;
      rcvd_q <= '0;
      lane_q <= '0;
      buf_q <= '0;
      dout_vld_q <= 1'b0;
      dout_last_q <= 1'b0;
      timed_out_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (num_cnt_read_valid_i && num_cnt_read_i != 16'd0) begin
        state_q <= FILL;
        target_q <= num_cnt_read_i;
        rcvd_q <= '0;
        lane_q <= '0;
        buf_q <= '0;
        timed_out_q <= 1'b0;
      end
    end else if (state_q == FILL) begin
      if (xfer) begin
        buf_q[{lane_q, 6'd0} +: 64] <= cnt_i;
        rcvd_q <= rcvd_q + 16'd1;
        lane_q <= lane_q + 3'd1;
        if (lane_q == 3'd7 || fin) begin
          state_q <= OUT;
          dout_vld_q <= 1'b1;
          dout_last_q <= fin;
        end
      end else if (flush) begin
        state_q <= OUT;
        dout_vld_q <= 1'b1;
        dout_last_q <= 1'b1;
        timed_out_q <= 1'b1;
      end
    end else if (dout_ready_i) begin
      dout_vld_q <= 1'b0;
      dout_last_q <= 1'b0;
      if (dout_last_q) begin
        done_q <= 1'b1;
        state_q <= IDLE;
      end else begin
        buf_q <= '0;
        state_q <= FILL;
      end
    end
  end
  assign dout_o = buf_q;
  assign dout_vld_o = dout_vld_q;
  assign dout_last_o = dout_last_q;
  assign done_o = done_q;
  assign timed_out_o = timed_out_q;
endmodule

// File: tb/tb_cnt_stream_packer.sv
// tb_cnt_stream_packer: random runs checked against a beat-list model built from the word list.
module tb_cnt_stream_packer;
  logic clk_i = 1'b0;
  logic reset_i, cnt_vld_i, num_cnt_read_valid_i, dout_ready_i;
  logic [63:0] cnt_i;
  logic [15:0] num_cnt_read_i;
  logic cnt_ack_o, dout_vld_o, dout_last_o, done_o, timed_out_o;
  logic [511:0] dout_o;
  int n_vec = 0, n_err = 0;
  cnt_stream_packer #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .cnt_i(cnt_i), .cnt_vld_i(cnt_vld_i), .cnt_ack_o(cnt_ack_o),
    .num_cnt_read_i(num_cnt_read_i), .num_cnt_read_valid_i(num_cnt_read_valid_i),
    .dout_o(dout_o), .dout_vld_o(dout_vld_o), .dout_ready_i(dout_ready_i),
    .dout_last_o(dout_last_o), .done_o(done_o), .timed_out_o(timed_out_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load(input int v);
    num_cnt_read_i = 16'(v);
    num_cnt_read_valid_i = 1'b1;
    @(negedge clk_i);
    num_cnt_read_valid_i = 1'b0;
  endtask
  task automatic run(input int n, input int vpct, input int rpct, input int base);
    logic [63:0] w[$];
    logic [512:0] exp_q[$];
    logic [511:0] beat;
    int wi = 0, nb, cyc = 0, gap = 0;
    bit vld_exp = 0, done_exp = 0, xf, acc;
    for (int i = 0; i < n; i++) w.push_back(base != 0 ? 64'(base + i) : {$urandom, $urandom});
    nb = (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int k = 0; k < 8; k++) if (b * 8 + k < n) beat[k*64 +: 64] = w[b*8+k];
      exp_q.push_back({b == nb - 1, beat});
    end
    load(n);
    forever begin
      chk("done", done_o, done_exp);
      if (done_exp) break;
      chk("dout_vld", dout_vld_o, vld_exp);
      chk("cnt_ack", cnt_ack_o, !vld_exp && wi < n);
      if (vld_exp) begin
        chk("dout", dout_o, exp_q[0][511:0]);
        chk("dout_last", dout_last_o, exp_q[0][512]);
      end
      if (++cyc > 3000) begin
        chk("run_bound", exp_q.size(), 0);
        break;
      end
      if (!cnt_vld_i && wi < n) begin
        if (gap >= 3 || $urandom_range(99) < vpct) begin
          cnt_vld_i = 1'b1;
          cnt_i = w[wi];
          gap = 0;
        end else gap++;
      end
      dout_ready_i = $urandom_range(99) < rpct;
      num_cnt_read_valid_i = $urandom_range(99) < 5;
      num_cnt_read_i = 16'($urandom);
      xf = cnt_vld_i && !vld_exp && wi < n;
      acc = vld_exp && dout_ready_i;
      done_exp = acc && exp_q[0][512];
      if (acc) begin
        void'(exp_q.pop_front());
        vld_exp = 0;
      end
      if (xf) begin
        wi++;
        vld_exp = wi % 8 == 0 || wi == n;
      end
      @(negedge clk_i);
      if (xf) cnt_vld_i = 1'b0;
    end
    num_cnt_read_valid_i = 1'b0;
    dout_ready_i = 1'b0;
    cnt_vld_i = 1'b1;
    cnt_i = {$urandom, $urandom};
    repeat (3) begin
      @(negedge clk_i);
      chk("idle_ack", cnt_ack_o, 0);
      chk("done_once", done_o, 0);
    end
    cnt_vld_i = 1'b0;
    chk("timed_out_clr", timed_out_o, 0);
  endtask
  initial begin
    logic [511:0] expb;
    int j;
    reset_i = 1'b1;
    cnt_vld_i = 1'b0;
    cnt_i = '0;
    num_cnt_read_i = '0;
    num_cnt_read_valid_i = 1'b0;
    dout_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ack", cnt_ack_o, 0);
    chk("rst_dout", dout_o, 0);
    chk("rst_vld", dout_vld_o, 0);
    chk("rst_last", dout_last_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_to", timed_out_o, 0);
    reset_i = 1'b0;
    run(16, 100, 100, 1);
    run(3, 100, 100, 'hA);
    run(9, 100, 10, 0);
    load(0);
    cnt_vld_i = 1'b1;
    repeat (5) begin
      chk("zero_ack", cnt_ack_o, 0);
      chk("zero_vld", dout_vld_o, 0);
      chk("zero_done", done_o, 0);
      @(negedge clk_i);
    end
    cnt_vld_i = 1'b0;
    run(8, 100, 100, 0);
    run(64, 100, 100, 0);
    for (int r = 0; r < 12; r++)
      run($urandom_range(1, 40), $urandom_range(30, 100), $urandom_range(20, 100), 0);
    load(12);
    cnt_vld_i = 1'b1;
    repeat (10) begin
      cnt_i = {$urandom, $urandom};
      @(negedge clk_i);
    end
    chk("pre_rst_vld", dout_vld_o, 1);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    cnt_vld_i = 1'b0;
    chk("mid_rst_ack", cnt_ack_o, 0);
    chk("mid_rst_dout", dout_o, 0);
    chk("mid_rst_vld", dout_vld_o, 0);
    chk("mid_rst_last", dout_last_o, 0);
    chk("mid_rst_done", done_o, 0);
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_done", done_o, 0);
    end
    run(1, 100, 100, 'hFF);
`ifdef CNT_FLUSH_TIMEOUT_EN
    load(10);
    cnt_vld_i = 1'b1;
    cnt_i = 64'h1111;
    @(negedge clk_i);
    cnt_i = 64'h2222;
    @(negedge clk_i);
    cnt_vld_i = 1'b0;
    j = 0;
    while (!dout_vld_o && j < 40) begin
      @(negedge clk_i);
      j++;
    end
    chk("to_delay", j, 16);
    expb = '0;
    expb[63:0] = 64'h1111;
    expb[127:64] = 64'h2222;
    chk("to_dout", dout_o, expb);
    chk("to_last", dout_last_o, 1);
    chk("to_flag", timed_out_o, 1);
    dout_ready_i = 1'b1;
    @(negedge clk_i);
    dout_ready_i = 1'b0;
    chk("to_done", done_o, 1);
    chk("to_vld_off", dout_vld_o, 0);
    @(negedge clk_i);
    chk("to_done_once", done_o, 0);
    chk("to_sticky", timed_out_o, 1);
    run(5, 100, 100, 0);
`else
    j = 0;
    expb = '0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
